// File: rtl/buffet_sb_pkg.sv
// Shared defaults and request-type encoding for the buffet_sb scoreboarded buffet.
package buffet_sb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_IDX_WIDTH  = 5;
    localparam int DEF_DEPTH      = 16;

    typedef enum logic {
        REQ_READ   = 1'b0,
        REQ_SHRINK = 1'b1
    } req_type_e;

endpackage

// File: rtl/buffet_sb_mem.sv
// DEPTH x DATA_WIDTH simple dual-port store: one write port, one enabled read port
// with a registered output that holds its value until the next read.
module buffet_sb_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     nreset_i,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Output register doubles as the response data holder, so only a read reloads it.
    always_ff @(posedge clk) begin
        if (!nreset_i) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/buffet_sb.sv
// Head-relative circular buffet with per-slot read-will-update scoreboard and batched credits.
// Optional macro BUFFET_UPDATE_FWD_EN forwards update data straight to a stalled read's response.
module buffet_sb
    import buffet_sb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH    = DEF_IDX_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int CREDIT_BATCH = 1
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_data_valid,
    output logic                  push_data_ready,
    input  logic [IDX_WIDTH-1:0]  read_idx,
    input  logic                  read_idx_valid,
    output logic                  read_idx_ready,
    input  logic                  read_will_update,
    input  logic                  is_shrink,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_data_valid,
    input  logic                  read_data_ready,
    input  logic [IDX_WIDTH-1:0]  update_idx,
    input  logic                  update_idx_valid,
    input  logic [DATA_WIDTH-1:0] update_data,
    input  logic                  update_data_valid,
    output logic                  update_ready,
    output logic                  update_receive_ack,
    output logic [IDX_WIDTH-1:0]  credit_out,
    output logic                  credit_valid,
    input  logic                  credit_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [IDX_WIDTH:0] ACC_RST  = (IDX_WIDTH+1)'(DEPTH);
    localparam logic [IDX_WIDTH:0] ACC_MAX  = {1'b0, {IDX_WIDTH{1'b1}}};
    localparam logic [IDX_WIDTH:0] ACC_BAT  = (IDX_WIDTH+1)'(CREDIT_BATCH);

    logic [AW-1:0]        r_head, r_tail;
    logic [AW:0]          r_occ;
    logic [DEPTH-1:0]     r_pending;
    logic [IDX_WIDTH:0]   r_acc;
    logic                 r_req_valid;
    req_type_e            r_req_type;
    logic [IDX_WIDTH-1:0] r_req_idx;
    logic                 r_req_wu;
    logic                 r_rsp_valid;
    logic                 r_ack;

    logic [AW-1:0]        w_head_next, w_tail_next;
    logic [AW:0]          w_occ_next;
    logic [DEPTH-1:0]     w_pending_next;
    logic [IDX_WIDTH:0]   w_acc_next;

    logic [IDX_WIDTH-1:0] w_occ_x;
    logic [AW-1:0]        w_req_slot, w_upd_slot;
    logic [DEPTH-1:0]     w_rel_pending, w_range_mask;
    logic                 w_req_is_shrink, w_rsp_free, w_shrink_block;
    logic                 w_issue_read, w_issue_shrink, w_fwd, w_req_done, w_req_accept;
    logic                 w_upd_fire, w_upd_in_range, w_upd_write, w_push_fire, w_credit_fire;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_occ_x         = IDX_WIDTH'(r_occ);
    assign w_req_slot      = r_head + r_req_idx[AW-1:0];
    assign w_upd_slot      = r_head + update_idx[AW-1:0];
    assign w_req_is_shrink = (r_req_type == REQ_SHRINK);
    assign w_rsp_free      = !r_rsp_valid || read_data_ready;

    // Pending bits rotated into head-relative order, masked to the shrink range 0..idx-1.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rel
        logic [AW-1:0] w_pos;
        assign w_pos             = r_head + AW'(gi);
        assign w_rel_pending[gi] = r_pending[w_pos];
        assign w_range_mask[gi]  = (IDX_WIDTH'(gi) < r_req_idx);
    end
    assign w_shrink_block = |(w_rel_pending & w_range_mask);

    assign w_issue_read   = r_req_valid && !w_req_is_shrink && (r_req_idx < w_occ_x)
                          && !r_pending[w_req_slot] && w_rsp_free;
    assign w_issue_shrink = r_req_valid && w_req_is_shrink && (r_req_idx <= w_occ_x)
                          && !w_shrink_block;
    assign w_req_done     = w_issue_read || w_issue_shrink || w_fwd;
    assign read_idx_ready = !r_req_valid;
    assign w_req_accept   = read_idx_valid && !r_req_valid;

    assign w_upd_fire     = update_idx_valid && update_data_valid;
    assign w_upd_in_range = (update_idx < w_occ_x);
    assign w_upd_write    = w_upd_fire && w_upd_in_range;
    assign update_ready   = 1'b1;

    // Updates own the single write port; a fill simply waits one cycle.
    assign push_data_ready = (r_occ < OCC_FULL) && !w_upd_write;
    assign w_push_fire     = push_data_valid && push_data_ready;

    assign credit_out    = (r_acc > ACC_MAX) ? {IDX_WIDTH{1'b1}} : r_acc[IDX_WIDTH-1:0];
    assign credit_valid  = (r_acc >= ACC_BAT) || ((r_acc != '0) && (r_occ == '0));
    assign w_credit_fire = credit_valid && credit_ready;

    always_comb begin
        w_head_next    = r_head;
        w_tail_next    = r_tail;
        w_pending_next = r_pending;
        w_occ_next     = r_occ + (AW+1)'(w_push_fire)
                       - (w_issue_shrink ? (AW+1)'(r_req_idx) : '0);
        w_acc_next     = r_acc - (w_credit_fire ? {1'b0, credit_out} : '0)
                       + (w_issue_shrink ? {1'b0, r_req_idx} : '0);
        if (w_push_fire) begin
            w_tail_next = r_tail + 1'b1;
        end
        if (w_issue_shrink) begin
            w_head_next = r_head + r_req_idx[AW-1:0];
        end
        if (w_upd_write) begin
            w_pending_next[w_upd_slot] = 1'b0;
        end
        if ((w_issue_read || w_fwd) && r_req_wu) begin
            w_pending_next[w_req_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset_i) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_occ       <= '0;
            r_pending   <= '0;
            r_acc       <= ACC_RST;
            r_req_valid <= 1'b0;
            r_req_type  <= REQ_READ;
            r_req_idx   <= '0;
            r_req_wu    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_head    <= w_head_next;
            r_tail    <= w_tail_next;
            r_occ     <= w_occ_next;
            r_pending <= w_pending_next;
            r_acc     <= w_acc_next;
            r_ack     <= w_upd_fire;
            if (w_req_accept) begin
                r_req_valid <= 1'b1;
                r_req_type  <= is_shrink ? REQ_SHRINK : REQ_READ;
                r_req_idx   <= read_idx;
                r_req_wu    <= read_will_update;
            end else if (w_req_done) begin
                r_req_valid <= 1'b0;
            end
            if (w_issue_read || w_fwd) begin
                r_rsp_valid <= 1'b1;
            end else if (read_data_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    buffet_sb_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk      (clk),
        .nreset_i (nreset_i),
        .i_we     (w_upd_write || w_push_fire),
        .i_waddr  (w_upd_write ? w_upd_slot : r_tail),
        .i_wdata  (w_upd_write ? update_data : push_data),
        .i_re     (w_issue_read),
        .i_raddr  (w_req_slot),
        .o_rdata  (w_mem_rdata)
    );

`ifdef BUFFET_UPDATE_FWD_EN
    logic                  r_rsp_fwd;
    logic [DATA_WIDTH-1:0] r_fwd_data;

    assign w_fwd = r_req_valid && !w_req_is_shrink && (r_req_idx < w_occ_x)
                 && r_pending[w_req_slot] && w_upd_write
                 && (w_upd_slot == w_req_slot) && w_rsp_free;

    always_ff @(posedge clk) begin
        if (!nreset_i) begin
            r_rsp_fwd  <= 1'b0;
            r_fwd_data <= '0;
        end else if (w_issue_read || w_fwd) begin
            r_rsp_fwd <= w_fwd;
            if (w_fwd) begin
                r_fwd_data <= update_data;
            end
        end
    end

    assign read_data = r_rsp_fwd ? r_fwd_data : w_mem_rdata;
`else
    assign w_fwd     = 1'b0;
    assign read_data = w_mem_rdata;
`endif

    assign read_data_valid    = r_rsp_valid;
    assign update_receive_ack = r_ack;

endmodule

// File: tb/tb_buffet_sb.sv
// Directed bench for buffet_sb at DEPTH=8, CREDIT_BATCH=1 with hand-computed expectations.
module tb_buffet_sb;

    localparam int DW = 16;
    localparam int IW = 5;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          nreset_i = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          push_data_valid = 1'b0;
    logic          push_data_ready;
    logic [IW-1:0] read_idx = '0;
    logic          read_idx_valid = 1'b0;
    logic          read_idx_ready;
    logic          read_will_update = 1'b0;
    logic          is_shrink = 1'b0;
    logic [DW-1:0] read_data;
    logic          read_data_valid;
    logic          read_data_ready = 1'b1;
    logic [IW-1:0] update_idx = '0;
    logic          update_idx_valid = 1'b0;
    logic [DW-1:0] update_data = '0;
    logic          update_data_valid = 1'b0;
    logic          update_ready;
    logic          update_receive_ack;
    logic [IW-1:0] credit_out;
    logic          credit_valid;
    logic          credit_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    buffet_sb #(
        .DATA_WIDTH   (DW),
        .IDX_WIDTH    (IW),
        .DEPTH        (D),
        .CREDIT_BATCH (1)
    ) dut (
        .clk                (clk),
        .nreset_i           (nreset_i),
        .push_data          (push_data),
        .push_data_valid    (push_data_valid),
        .push_data_ready    (push_data_ready),
        .read_idx           (read_idx),
        .read_idx_valid     (read_idx_valid),
        .read_idx_ready     (read_idx_ready),
        .read_will_update   (read_will_update),
        .is_shrink          (is_shrink),
        .read_data          (read_data),
        .read_data_valid    (read_data_valid),
        .read_data_ready    (read_data_ready),
        .update_idx         (update_idx),
        .update_idx_valid   (update_idx_valid),
        .update_data        (update_data),
        .update_data_valid  (update_data_valid),
        .update_ready       (update_ready),
        .update_receive_ack (update_receive_ack),
        .credit_out         (credit_out),
        .credit_valid       (credit_valid),
        .credit_ready       (credit_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // One clock; a request that was being handshaken is withdrawn after the edge.
    task automatic step();
        logic acc;
        acc = read_idx_valid && read_idx_ready;
        @(posedge clk);
        #1;
        if (acc) read_idx_valid = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        push_data       = d;
        push_data_valid = 1'b1;
        step();
        push_data_valid = 1'b0;
    endtask

    task automatic upd(input logic [IW-1:0] idx, input logic [DW-1:0] d, input string tag);
        update_idx        = idx;
        update_data       = d;
        update_idx_valid  = 1'b1;
        update_data_valid = 1'b1;
        step();
        update_idx_valid  = 1'b0;
        update_data_valid = 1'b0;
        check({tag, "_ack"}, 32'(update_receive_ack), 32'd1);
    endtask

    task automatic read_req(input logic [IW-1:0] idx, input logic wu,
                            input logic [DW-1:0] exp, input string tag);
        read_idx         = idx;
        read_will_update = wu;
        is_shrink        = 1'b0;
        read_idx_valid   = 1'b1;
        step();
        read_will_update = 1'b0;
        check({tag, "_t1_novalid"}, 32'(read_data_valid), 32'd0);
        step();
        check({tag, "_t2_valid"}, 32'(read_data_valid), 32'd1);
        check({tag, "_data"}, 32'(read_data), 32'(exp));
        step();
    endtask

    task automatic wait_rsp(input logic [DW-1:0] exp, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (read_data_valid) begin
                got = 1'b1;
                check({tag, "_data"}, 32'(read_data), 32'(exp));
            end
            step();
        end
        check({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int n_rdv;
        int n_rdy;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdv", 32'(read_data_valid), 32'd0);
        check("rst_ack", 32'(update_receive_ack), 32'd0);
        check("rst_rdata", 32'(read_data), 32'd0);
        check("rst_cvalid", 32'(credit_valid), 32'd1);
        check("rst_credit", 32'(credit_out), 32'd8);
        check("rst_rd_rdy", 32'(read_idx_ready), 32'd1);
        check("rst_push_rdy", 32'(push_data_ready), 32'd1);
        check("rst_upd_rdy", 32'(update_ready), 32'd1);
        nreset_i = 1'b1;
        step();

        credit_ready = 1'b1;
        step();
        credit_ready = 1'b0;
        check("credit_drained", 32'(credit_valid), 32'd0);

        for (int i = 0; i < 5; i++) push(DW'(16'h1000 + i));
        check("fill5_occ", 32'(dut.r_occ), 32'd5);
        read_req(5'd0, 1'b1, 16'h1000, "rd0_wu");
        read_req(5'd1, 1'b1, 16'h1001, "rd1_wu");

        read_data_ready  = 1'b0;
        read_idx         = 5'd2;
        read_will_update = 1'b1;
        read_idx_valid   = 1'b1;
        step();
        read_will_update = 1'b0;
        step();
        check("rd2_valid", 32'(read_data_valid), 32'd1);
        repeat (3) step();
        check("rd2_hold_valid", 32'(read_data_valid), 32'd1);
        check("rd2_hold_data", 32'(read_data), 32'h1002);
        read_data_ready = 1'b1;
        step();
        check("rd2_drained", 32'(read_data_valid), 32'd0);
        check("pending_012", 32'(dut.r_pending), 32'h07);

        read_idx       = 5'd1;
        read_idx_valid = 1'b1;
        step();
        read_idx       = 5'd4;
        read_idx_valid = 1'b1;
        n_rdv = 0;
        n_rdy = 0;
        repeat (100) begin
            step();
            if (read_data_valid) n_rdv++;
            if (read_idx_ready) n_rdy++;
        end
        check("stall_no_rsp", 32'(n_rdv), 32'd0);
        check("stall_rd_rdy", 32'(n_rdy), 32'd0);

        update_idx        = 5'd1;
        update_data       = 16'h00AB;
        update_idx_valid  = 1'b1;
        update_data_valid = 1'b1;
        step();
        update_idx_valid  = 1'b0;
        update_data_valid = 1'b0;
        check("upd1_ack", 32'(update_receive_ack), 32'd1);
`ifdef BUFFET_UPDATE_FWD_EN
        check("upd1_fwd_rdv", 32'(read_data_valid), 32'd1);
`else
        check("upd1_nofwd_rdv", 32'(read_data_valid), 32'd0);
`endif
        wait_rsp(16'h00AB, "rd1_updated");
        wait_rsp(16'h1004, "rd4_orig");
        check("ack_pulse_low", 32'(update_receive_ack), 32'd0);

        upd(5'd0, 16'h00C0, "upd0");
        upd(5'd2, 16'h00C2, "upd2");
        check("pending_clear", 32'(dut.r_pending), 32'h00);
        upd(5'd6, 16'h00EE, "upd_oor");
        check("upd_oor_occ", 32'(dut.r_occ), 32'd5);

        for (int i = 5; i < 8; i++) push(DW'(16'h1000 + i));
        check("full_push_rdy", 32'(push_data_ready), 32'd0);
        check("full_cvalid", 32'(credit_valid), 32'd0);

        read_idx       = 5'd3;
        is_shrink      = 1'b1;
        read_idx_valid = 1'b1;
        step();
        step();
        is_shrink = 1'b0;
        check("shr3_cvalid", 32'(credit_valid), 32'd1);
        check("shr3_credit", 32'(credit_out), 32'd3);
        check("shr3_push_rdy", 32'(push_data_ready), 32'd1);
        check("shr3_occ", 32'(dut.r_occ), 32'd5);
        check("shr3_no_rsp", 32'(read_data_valid), 32'd0);
        credit_ready = 1'b1;
        step();
        credit_ready = 1'b0;
        check("shr3_credit_taken", 32'(credit_valid), 32'd0);

        read_req(5'd0, 1'b0, 16'h1003, "rd_head3");
        read_req(5'd4, 1'b0, 16'h1007, "rd_head3_off4");

        read_req(5'd2, 1'b1, 16'h1005, "rd_off2_wu");
        check("pending_slot5", 32'(dut.r_pending), 32'h20);
        read_idx       = 5'd4;
        is_shrink      = 1'b1;
        read_idx_valid = 1'b1;
        step();
        repeat (5) step();
        check("shr4_stall_occ", 32'(dut.r_occ), 32'd5);
        check("shr4_stall_rdy", 32'(read_idx_ready), 32'd0);
        upd(5'd2, 16'h00D5, "upd_off2");
        step();
        is_shrink = 1'b0;
        check("shr4_occ", 32'(dut.r_occ), 32'd1);
        check("shr4_credit", 32'(credit_out), 32'd4);
        check("shr4_rd_rdy", 32'(read_idx_ready), 32'd1);

        push(16'h2000);
        read_req(5'd1, 1'b0, 16'h2000, "rd_wrap");

        read_req(5'd0, 1'b1, 16'h1007, "rd_last_wu");
        read_idx       = 5'd0;
        read_idx_valid = 1'b1;
        step();
        repeat (3) step();
        check("pre_rst_stall", 32'(read_idx_ready), 32'd0);
        nreset_i = 1'b0;
        step();
        check("midrst_credit", 32'(credit_out), 32'd8);
        check("midrst_cvalid", 32'(credit_valid), 32'd1);
        check("midrst_occ", 32'(dut.r_occ), 32'd0);
        check("midrst_rdv", 32'(read_data_valid), 32'd0);
        check("midrst_pending", 32'(dut.r_pending), 32'h00);
        check("midrst_rd_rdy", 32'(read_idx_ready), 32'd1);
        nreset_i = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
